// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with 8-beat line refill.
// Optional ICACHE_PERF_EN adds hit_count/miss_count outputs.
module icache #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int NUM_SETS       = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               pc,
  input  logic [63:0]               stackptr,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      data_ack,
  output logic [31:0]               instr_reg
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 58 - IDX_W;
  localparam logic [12:0] REQ_TAG = {1'b1, 4'b0001, 8'h00};

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t                    state, next_state;
  logic [57:0]               miss_line;
  logic [2:0]                beat_cnt;
  logic [NUM_SETS-1:0]       valid;
  logic [TAG_W-1:0]          tag_mem  [NUM_SETS];
  logic [BUS_DATA_WIDTH-1:0] data_mem [NUM_SETS*8];

  logic [IDX_W-1:0]          pc_index, fill_index;
  logic [TAG_W-1:0]          pc_tag, fill_tag;
  logic                      hit;
  logic [BUS_DATA_WIDTH-1:0] rd_beat;
  logic                      miss_start, fill_beat, fill_done;
  logic                      unused_inputs;

  assign unused_inputs = ^{stackptr, bus_resptag, pc[1:0]};

  assign pc_index   = pc[6 +: IDX_W];
  assign pc_tag     = pc[63 -: TAG_W];
  assign fill_index = miss_line[IDX_W-1:0];
  assign fill_tag   = miss_line[57 -: TAG_W];
  assign hit        = valid[pc_index] && (tag_mem[pc_index] == pc_tag);
  assign rd_beat    = data_mem[{pc_index, pc[5:3]}];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    data_ack    = 1'b0;
    instr_reg   = '0;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = bus_respcyc;  // beats are always consumed; strays are simply not written
    miss_start  = 1'b0;
    fill_beat   = 1'b0;
    fill_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (hit) begin
          data_ack  = 1'b1;
          instr_reg = pc[2] ? rd_beat[63:32] : rd_beat[31:0];
        end else begin
          miss_start = 1'b1;
          next_state = S_REQ;
        end
      end
      S_REQ: begin
        bus_reqcyc = 1'b1;
        bus_req    = BUS_DATA_WIDTH'({miss_line, 6'b0});
        bus_reqtag = BUS_TAG_WIDTH'(REQ_TAG);
        if (bus_reqack) next_state = S_RESP;
      end
      S_RESP: begin
        if (bus_respcyc) begin
          fill_beat = 1'b1;
          if (beat_cnt == 3'd7) begin
            fill_done  = 1'b1;
            next_state = S_IDLE;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
    // Reset dominates the lookup so stale valid bits never produce an ack.
    if (reset) begin
      next_state = S_IDLE;
      data_ack   = 1'b0;
      instr_reg  = '0;
      bus_reqcyc = 1'b0;
      bus_req    = '0;
      bus_reqtag = '0;
      miss_start = 1'b0;
      fill_beat  = 1'b0;
      fill_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid     <= '0;
      beat_cnt  <= '0;
      miss_line <= '0;
    end else begin
      if (miss_start) miss_line <= pc[63:6];
      if (state == S_REQ && bus_reqack) beat_cnt <= '0;
      else if (fill_beat)               beat_cnt <= beat_cnt + 3'd1;
      if (fill_done) valid[fill_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_beat) data_mem[{fill_index, beat_cnt}] <= bus_resp;
    if (fill_done) tag_mem[fill_index] <= fill_tag;
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (data_ack)   hit_count  <= hit_count + 32'd1;
      if (miss_start) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard bench for icache: refill, hits, conflicts, slow bus, mid-fill reset.
module tb_icache;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc, stackptr;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack, bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack, data_ack;
  logic [31:0] instr_reg;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [63:0] req_q[$];

  icache dut (
    .clk(clk), .reset(reset), .pc(pc), .stackptr(stackptr),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .data_ack(data_ack), .instr_reg(instr_reg)
`ifdef ICACHE_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory image: the 32-bit word at byte address a holds (a - 0x1000) / 4.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [31:0] b;
    b = a[31:0] & 32'hFFFF_FFFC;
    return (b - 32'h1000) >> 2;
  endfunction

  function automatic logic [63:0] beat_at(input logic [63:0] line, input int i);
    logic [63:0] a;
    a = line + 64'(8 * i);
    return {word_at(a + 64'd4), word_at(a)};
  endfunction

  task automatic fill_line(input int delay, input int gap, input int beats);
    logic [63:0] exp_addr;
    int t;
    t = 0;
    while (bus_reqcyc !== 1'b1 && t < 20) begin
      @(negedge clk); #1; t++;
    end
    exp_addr = req_q.pop_front();
    n_cmp++;
    if (bus_reqcyc !== 1'b1) begin
      n_err++;
      $display("FAIL req_timeout: bus_reqcyc=%b expected 1 for line %h", bus_reqcyc, exp_addr);
      return;
    end
    n_cmp++;
    if (bus_req !== exp_addr) begin
      n_err++; $display("FAIL req_addr: got %h expected %h", bus_req, exp_addr);
    end
    n_cmp++;
    if (bus_reqtag !== 13'h1100) begin
      n_err++; $display("FAIL req_tag: got %h expected 1100", bus_reqtag);
    end
    for (int d = 0; d < delay; d++) begin
      stackptr = {$urandom, $urandom};
      @(negedge clk); #1;
      n_cmp++;
      if (bus_reqcyc !== 1'b1 || bus_req !== exp_addr) begin
        n_err++;
        $display("FAIL req_hold: reqcyc=%b req=%h expected 1 %h", bus_reqcyc, bus_req, exp_addr);
      end
    end
    bus_reqack = 1'b1;
    @(negedge clk);
    bus_reqack = 1'b0;
    for (int i = 0; i < beats; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus_respcyc = 1'b0;
        stackptr = {$urandom, $urandom};
        #1;
        n_cmp++;
        if (bus_respack !== 1'b0 || data_ack !== 1'b0) begin
          n_err++; $display("FAIL gap: respack=%b data_ack=%b expected 0 0", bus_respack, data_ack);
        end
        @(negedge clk);
      end
      bus_respcyc = 1'b1;
      bus_resp    = beat_at(exp_addr, i);
      bus_resptag = 13'($urandom);
      #1;
      n_cmp++;
      if (bus_respack !== 1'b1 || data_ack !== 1'b0 || instr_reg !== 32'h0 || bus_reqcyc !== 1'b0) begin
        n_err++;
        $display("FAIL beat%0d: respack=%b ack=%b instr=%h reqcyc=%b expected 1 0 0 0",
                 i, bus_respack, data_ack, instr_reg, bus_reqcyc);
      end
      @(negedge clk);
    end
    bus_respcyc = 1'b0;
  endtask

  task automatic check_hits(input logic [63:0] base, input int n, input int step);
    logic [31:0] e;
    for (int k = 0; k < n; k++) begin
      pc = base + 64'(k * step);
      stackptr = {$urandom, $urandom};
      exp_q.push_back(word_at(pc));
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (data_ack !== 1'b1 || instr_reg !== e) begin
        n_err++;
        $display("FAIL hit pc=%h: ack=%b instr=%h expected 1 %h", pc, data_ack, instr_reg, e);
      end
      n_cmp++;
      if (bus_reqcyc !== 1'b0 || bus_req !== 64'h0 || bus_reqtag !== 13'h0) begin
        n_err++;
        $display("FAIL hit_bus pc=%h: reqcyc=%b req=%h tag=%h expected all 0", pc, bus_reqcyc, bus_req, bus_reqtag);
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_miss(input logic [63:0] addr, input string name);
    pc = addr;
    req_q.push_back({addr[63:6], 6'b0});
    #1;
    n_cmp++;
    if (data_ack !== 1'b0 || instr_reg !== 32'h0) begin
      n_err++; $display("FAIL %s: ack=%b instr=%h expected 0 0", name, data_ack, instr_reg);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; pc = 64'h1000; stackptr = '0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (data_ack !== 1'b0 || instr_reg !== 32'h0) begin
      n_err++; $display("FAIL reset_fetch: ack=%b instr=%h expected 0 0", data_ack, instr_reg);
    end
    n_cmp++;
    if (bus_reqcyc !== 1'b0 || bus_req !== 64'h0 || bus_reqtag !== 13'h0) begin
      n_err++; $display("FAIL reset_bus: reqcyc=%b req=%h tag=%h expected 0", bus_reqcyc, bus_req, bus_reqtag);
    end
    reset = 1'b0;
    expect_miss(64'h1000, "cold_miss");
  endtask

  task automatic test_cold_miss;
    fill_line(0, 0, 8);
    check_hits(64'h1000, 3, 4);
  endtask

  task automatic test_sequential_hits;
    check_hits(64'h1000, 16, 4);
    check_hits(64'h1003, 1, 0);
    check_hits(64'h103F, 1, 0);
  endtask

  task automatic test_conflict;
    expect_miss(64'h2000, "conflict_miss");
    fill_line(0, 0, 8);
    check_hits(64'h2000, 16, 4);
    expect_miss(64'h1000, "return_miss");
  endtask

  task automatic test_slow_bus;
    fill_line(5, 2, 8);
    check_hits(64'h1000, 16, 4);
  endtask

  task automatic test_reset_mid_fill;
    expect_miss(64'h1040, "mid_miss");
    fill_line(0, 0, 4);
    reset = 1'b1; pc = 64'h1000;
    bus_respcyc = 1'b1; bus_resp = {$urandom, $urandom};
    #1;
    n_cmp++;
    if (data_ack !== 1'b0 || bus_reqcyc !== 1'b0 || bus_respack !== 1'b1) begin
      n_err++; $display("FAIL reset_mid: ack=%b reqcyc=%b respack=%b expected 0 0 1", data_ack, bus_reqcyc, bus_respack);
    end
    @(negedge clk);
    reset = 1'b0;
    bus_resp = {$urandom, $urandom};
    #1;
    n_cmp++;
    if (data_ack !== 1'b0 || bus_respack !== 1'b1 || bus_reqcyc !== 1'b0) begin
      n_err++; $display("FAIL stray_idle: ack=%b respack=%b reqcyc=%b expected 0 1 0", data_ack, bus_respack, bus_reqcyc);
    end
    @(negedge clk);
    bus_resp = {$urandom, $urandom};
    #1;
    n_cmp++;
    if (bus_respack !== 1'b1 || bus_reqcyc !== 1'b1 || bus_req !== 64'h1000) begin
      n_err++; $display("FAIL stray_req: respack=%b reqcyc=%b req=%h expected 1 1 1000", bus_respack, bus_reqcyc, bus_req);
    end
    @(negedge clk);
    bus_respcyc = 1'b0;
    req_q.push_back(64'h1000);
    fill_line(0, 1, 8);
    check_hits(64'h1000, 4, 4);
    expect_miss(64'h1040, "abandoned_line");
    fill_line(3, 0, 8);
    check_hits(64'h1040, 16, 4);
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf;
    reset = 1'b1; pc = 64'h1080;
    @(negedge clk); #1;
    n_cmp++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_err++; $display("FAIL perf_reset: hits=%0d misses=%0d expected 0 0", hit_count, miss_count);
    end
    @(negedge clk);
    reset = 1'b0;
    req_q.push_back(64'h1080);
    fill_line(0, 0, 8);
    check_hits(64'h1080, 5, 4);
    #1;
    n_cmp++;
    if (hit_count !== 32'd5 || miss_count !== 32'd1) begin
      n_err++; $display("FAIL perf_count: hits=%0d misses=%0d expected 5 1", hit_count, miss_count);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_cold_miss;
    test_sequential_hits;
    test_conflict;
    test_slow_bus;
    test_reset_mid_fill;
`ifdef ICACHE_PERF_EN
    test_perf;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
